// File: rtl/vector_sub_seq_if.sv
// Handshake bundle for vector_sub_seq: operand-side valid/ready with two
// LEN-element vectors, and result-side valid/ready with difference vector,
// per-element borrow flags and a busy indicator.
//   master : producer/consumer side (drives in_valid, a, b, out_ready)
//   slave  : the subtractor (drives in_ready, out_valid, diff, borrow, busy)
interface vector_sub_seq_if #(
  parameter int WIDTH = 32,
  parameter int LEN   = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a      [LEN-1:0];
  logic [WIDTH-1:0] b      [LEN-1:0];
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff   [LEN-1:0];
  logic [LEN-1:0]   borrow;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, busy
  );
endinterface

// File: rtl/vector_sub_seq.sv
// Element-serial vector subtractor: diff[i] = a[i] - b[i] (mod 2^WIDTH), borrow[i] = a[i] < b[i].
// Latency: LEN cycles from input accept to out_valid; one vector pair per LEN+2 cycles sustained.
// Backpressure: result held stable in DONE while out_ready is low; in_ready low until handshake.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - vector_sub_seq_if.slave: in_valid/in_ready + a/b operands,
//           out_valid/out_ready + diff/borrow results, busy (CALC or DONE)
module vector_sub_seq #(
  parameter int WIDTH = 32,
  parameter int LEN   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  vector_sub_seq_if.slave bus
);

  // A single-element vector still needs a 1-bit index register.
  localparam int               IDX_W    = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [WIDTH-1:0] a_q    [LEN-1:0];
  logic [WIDTH-1:0] b_q    [LEN-1:0];
  logic [WIDTH-1:0] diff_q [LEN-1:0];
  logic [LEN-1:0]   borrow_q;

  logic             accept;
  logic             calc_en;
  logic             in_ready;
  logic             out_valid;
  logic             busy;

  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH:0]   sub_res;

  // The one shared subtractor. Zero-extending both operands by a bit makes
  // the top bit of the result the unsigned borrow (set exactly when a < b).
  assign a_sel   = a_q[idx_q];
  assign b_sel   = b_q[idx_q];
  assign sub_res = {1'b0, a_sel} - {1'b0, b_sel};

  // Next-state and handshake outputs. Outputs depend on state_q only, so
  // there is no combinational path from in_valid or out_ready.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    accept    = 1'b0;
    calc_en   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          idx_d   = '0;
          state_d = CALC;
        end
      end

      CALC: begin
        busy    = 1'b1;
        calc_en = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, index, operand and result registers. Reset also clears the
  // result registers so an aborted operation leaves nothing visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      borrow_q <= '0;
      for (int i = 0; i < LEN; i++) begin
        a_q[i]    <= '0;
        b_q[i]    <= '0;
        diff_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;

      // Operands are sampled only on the accept edge; the inputs are free
      // to change afterwards.
      if (accept) begin
        for (int i = 0; i < LEN; i++) begin
          a_q[i] <= bus.a[i];
          b_q[i] <= bus.b[i];
        end
      end

      // One element per cycle; earlier elements of the previous result stay
      // visible until they are overwritten.
      if (calc_en) begin
        diff_q[idx_q]   <= sub_res[WIDTH-1:0];
        borrow_q[idx_q] <= sub_res[WIDTH];
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;

endmodule

// File: doc/vector_sub_seq.md
# vector_sub_seq

Element-serial vector subtractor. It accepts two LEN-element vectors through a valid/ready handshake and computes `diff[i] = a[i] - b[i]` one element per cycle, using a single WIDTH-bit subtractor. It presents the result vector, with per-element borrow flags, through a second valid/ready handshake. It is the inverse-direction companion to the combinational vector adder in the internal vector-math library, traded for area: one subtractor instead of LEN.

## Interface
Parameters:
- `WIDTH`, default 32: bits per element.
- `LEN`, default 8: elements per vector; must be ≥ 1.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: `a` and `b` are valid.
- `in_ready`  out  1: block can accept a vector pair.
- `a`  in  WIDTH × LEN (unpacked `[LEN-1:0]`): minuend vector.
- `b`  in  WIDTH × LEN (unpacked `[LEN-1:0]`): subtrahend vector.
- `out_valid`  out  1: `diff` and `borrow` hold a complete result.
- `out_ready`  in  1: consumer accepts the result.
- `diff`  out  WIDTH × LEN (unpacked `[LEN-1:0]`): element-wise difference.
- `borrow`  out  LEN: `borrow[i]` = 1 when `a[i] < b[i]` (unsigned).
- `busy`  out  1: high in CALC and DONE.

## Operation
- State machine states: IDLE, CALC, DONE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid && in_ready`, register all of `a` and `b` into internal operand registers, set `idx`=0, and go to CALC.
  - `a` and `b` are sampled only on the accept edge; later changes on the inputs are ignored.
- **CALC:**
  - Each cycle: `diff_r[idx]` ← `a_r[idx] - b_r[idx]`, truncated to WIDTH bits (modulo 2^WIDTH).
  - Each cycle: `borrow_r[idx]` ← carry-out inverted, i.e. `a_r[idx] < b_r[idx]` unsigned.
  - If `idx == LEN-1`, go to DONE; else `idx` ← `idx+1`.
  - `idx` width is `$clog2(LEN)`, minimum 1 bit.
- **DONE:**
  - `out_valid`=1.
  - `diff` and `borrow` are stable until the handshake.
  - On `out_valid && out_ready`, go to IDLE.
- `in_ready`=0 in CALC and DONE; `in_valid` asserted in those states is ignored and nothing is captured.
- `out_valid`=0 in IDLE and CALC.
- `diff` and `borrow` are driven directly from the result registers. They retain the last result after the output handshake and are overwritten element by element during the next CALC.
- No signed interpretation inside the block. Two's-complement consumers use `diff` as-is; `borrow` is the unsigned comparison only.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - State goes to IDLE; `idx`=0.
  - All operand and result registers go to 0.
  - Outputs: `in_ready`=1, `out_valid`=0, `busy`=0, `diff`=all 0, `borrow`=0.
- Reset asserted mid-CALC or mid-DONE aborts the operation. The partial result is discarded (cleared), and no `out_valid` pulse occurs.
- Latency: input accepted at edge T; elements computed at edges T+1 … T+LEN; `out_valid`=1 after edge T+LEN.
  - LEN=8: 8 cycles accept-to-valid.
  - LEN=1: 1 cycle.
- Output handshake at edge U: `in_ready`=1 after edge U. The earliest next accept is edge U+1.
- Sustained throughput: one vector pair per LEN+2 cycles when `out_ready` is tied high.
- Backpressure: with `out_ready`=0, DONE holds indefinitely; outputs do not change.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.

## Test plan
- **Basic:** WIDTH=32, LEN=8, `a[i]`=100+i, `b[i]`=i, accept at T.
  - Required: `out_valid` rises after T+8.
  - Required: every `diff[i]`=100, `borrow`=8'h00.
  - Required: `in_ready`=0 from T+1 until the output handshake.
- **Wrap/borrow:** `a[i]`=0, `b[i]`=1 for even i; `a[i]`=5, `b[i]`=5 for odd i.
  - Required: even `diff[i]`=32'hFFFF_FFFF and odd `diff[i]`=0.
  - Required: `borrow`=8'b0101_0101.
- **Backpressure:** hold `out_ready`=0 for 20 cycles after `out_valid`.
  - Required: `out_valid`, `diff` and `borrow` stay constant.
  - Required: `in_valid` pulses with new data are not accepted.
  - Required: after `out_ready`=1, one handshake occurs, then `in_ready`=1.
- **Back-to-back:** `out_ready` and `in_valid` tied high, three vector pairs.
  - Required: accepts spaced exactly LEN+2 cycles apart.
  - Required: each result matches its own inputs; changing `a`/`b` during CALC does not corrupt results.
- **Reset mid-operation:** assert `rst_n`=0 two cycles into CALC, asynchronously between clock edges.
  - Required immediately: `out_valid`=0, `busy`=0, `in_ready`=1, `diff`=0, `borrow`=0.
  - Required: the next vector pair after reset release produces a correct result.
- **LEN=1, WIDTH=8:** `a`=8'h10, `b`=8'h20.
  - Required: `out_valid` one cycle after accept.
  - Required: `diff`=8'hF0, `borrow`=1.
